memory_access_controller: RTL
=============================

Name: memory_access_controller

Overview:
- Sequencer directly upstream of memory_unit. It accepts single-word load/store requests from the CPU control FSM over a valid/ready handshake and drives memory_unit's rw_flag, address and write_memory_value.
- It samples read_memory_value into a response register and returns completion to the control FSM over a second valid/ready handshake.
- It guarantees the memory port sees exactly one write cycle per store, and no writes otherwise.

Parameters:
- ADDR_LIMIT, `MEMSIZE, number of valid word addresses; used only by the optional bounds check.

Ports:
- CLOCK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_address  in  `REGSIZE  word address.
- req_write_value  in  `REGSIZE  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_read_value  out  `REGSIZE  load data; 0 for stores.
- resp_error  out  1  out-of-range access flag.
- rw_flag  out  MEMORY_FLAG_TYPE  to memory_unit.
- address  out  `REGSIZE  to memory_unit.
- write_memory_value  out  `REGSIZE  to memory_unit.
- read_memory_value  in  `REGSIZE  from memory_unit (combinational read).

Behaviour:
- States and outputs:
  - IDLE: req_ready=1.
  - ACCESS: exactly one cycle.
  - RESP: resp_valid=1.
- Transitions:
  - IDLE -> ACCESS on req_valid && req_ready. req_write, req_address and req_write_value are captured into internal registers on that edge.
  - ACCESS -> RESP unconditionally.
  - RESP -> IDLE on resp_ready. RESP holds indefinitely while resp_ready=0, with resp_read_value and resp_error stable.
- Request acceptance:
  - req_ready=0 in ACCESS and RESP.
  - Requests presented then are not accepted and must be held by the requester.
- Memory port:
  - address and write_memory_value are always driven from the captured registers.
  - rw_flag=MEMORY_WRITE only in ACCESS with a captured store. It is MEMORY_READ in every other state and cycle.
- Load: at the ACCESS->RESP edge, read_memory_value is registered into resp_read_value.
- Store:
  - memory_unit commits on the ACCESS->RESP edge.
  - resp_read_value=0.
- Latency: request accepted at edge k; ACCESS cycle is k..k+1; resp_valid=1 after edge k+1. Minimum 3 cycles per transaction with resp_ready held at 1.
- Reset values (RESET high at an edge):
  - state=IDLE.
  - captured registers=0, so address=0 and write_memory_value=0.
  - resp_valid=0, resp_read_value=0, resp_error=0.
- Reset combinational forcing: while RESET is high, rw_flag is forced to MEMORY_READ and req_ready to 0.
- Reset mid-operation: an in-flight request or unconsumed response is discarded, and no write is issued.
- Handshake rules: resp_valid never drops without resp_ready. No combinational path from req_valid to req_ready, or from resp_ready to resp_valid.
- Width rules: all data paths are `REGSIZE bits with no arithmetic. The address is forwarded unmodified.

Optional Feature:
- Macro: MEMORY_BOUNDS_CHECK_EN.
- Defined:
  - At acceptance, a captured address >= ADDR_LIMIT marks the request faulted.
  - A faulted request still passes through ACCESS, but rw_flag stays MEMORY_READ.
  - In RESP, resp_error=1 and resp_read_value=0.
  - An address equal to ADDR_LIMIT-1 is valid.
- Not defined: resp_error is tied to 0 and all addresses are forwarded as-is.

Test Plan:
- Reset then idle:
  - RESET high 2 cycles, then low -> req_ready=1, resp_valid=0, rw_flag=MEMORY_READ, address=0.
- Store then load:
  - Store 0x5A to address 3, with resp_ready=1 -> rw_flag=MEMORY_WRITE for exactly 1 cycle with address=3; resp_valid after 2 edges; resp_read_value=0.
  - Then load address 3 -> resp_read_value=0x5A.
- Backpressure:
  - Load, with resp_ready=0 for 5 cycles -> resp_valid held, data stable, req_ready=0.
  - A new req_valid during that time is not accepted.
  - resp_ready=1 -> IDLE next cycle.
- Reset mid-store: assert RESET in the ACCESS cycle of a store to address 7 -> no MEMORY_WRITE observed; resp_valid=0; IDLE afterwards.
- Back-to-back loads of addresses 0, 1, 2 with req_valid and resp_ready held at 1 -> accepts spaced 3 cycles apart; data matches the preloaded memory.
- With MEMORY_BOUNDS_CHECK_EN and ADDR_LIMIT=16:
  - Store to address 16 -> rw_flag never MEMORY_WRITE; resp_error=1.
  - Store to address 15 -> normal write; resp_error=0.

Source files
------------

// File: rtl/memory_access_controller.sv
// memory_access_controller: single-word load/store sequencer for memory_unit.
// Optional MEMORY_BOUNDS_CHECK_EN faults requests whose address >= ADDR_LIMIT.
`ifndef REGSIZE
`define REGSIZE 32
`endif
`ifndef MEMSIZE
`define MEMSIZE 1024
`endif

package memory_pkg;
  typedef enum logic {
    MEMORY_READ  = 1'b0,
    MEMORY_WRITE = 1'b1
  } MEMORY_FLAG_TYPE;
endpackage

module memory_access_controller
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = `MEMSIZE
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [`REGSIZE-1:0] req_address,
  input  logic [`REGSIZE-1:0] req_write_value,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [`REGSIZE-1:0] resp_read_value,
  output logic                resp_error,
  output MEMORY_FLAG_TYPE     rw_flag,
  output logic [`REGSIZE-1:0] address,
  output logic [`REGSIZE-1:0] write_memory_value,
  input  logic [`REGSIZE-1:0] read_memory_value
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t              state;
  logic                cap_write;
  logic                cap_fault;
  logic                wr_q;
  logic [`REGSIZE-1:0] cap_address;
  logic [`REGSIZE-1:0] cap_value;
  logic                req_fault;

`ifdef MEMORY_BOUNDS_CHECK_EN
  assign req_fault =
    req_address >= `REGSIZE'(ADDR_LIMIT);
`else
  // Bounds check compiled out: never fault.
  assign req_fault =
    1'b0 & (req_address >= `REGSIZE'(ADDR_LIMIT));
`endif

  assign req_ready = (state == IDLE) && !RESET;
  assign address = cap_address;
  assign write_memory_value = cap_value;
  assign rw_flag =
    (wr_q && !RESET) ? MEMORY_WRITE : MEMORY_READ;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state           <= IDLE;
      cap_write       <= 1'b0;
      cap_fault       <= 1'b0;
      wr_q            <= 1'b0;
      cap_address     <= '0;
      cap_value       <= '0;
      resp_valid      <= 1'b0;
      resp_read_value <= '0;
      resp_error      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            cap_write   <= req_write;
            cap_fault   <= req_fault;
            cap_address <= req_address;
            cap_value   <= req_write_value;
            wr_q        <= req_write && !req_fault;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          // wr_q is high for exactly this one cycle.
          wr_q       <= 1'b0;
          resp_valid <= 1'b1;
          resp_error <= cap_fault;
          if (cap_write || cap_fault)
            resp_read_value <= '0;
          else
            resp_read_value <= read_memory_value;
          state <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
